// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit; XLEN+2 cycles start-to-done (1 cycle on div fast paths).
// Holds stall high from acceptance through FIX; start is only sampled in IDLE, flush aborts from any state.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg_res;
  logic              neg_rem;
  // Shared datapath: mul uses {acc_hi,acc_lo} as product with multiplier in acc_lo;
  // div uses acc_hi as remainder, acc_lo as dividend shifting into quotient.
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   opb;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic              is_div, b_zero, ovf, fast;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res;

  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   mul_res, div_res, fix_res;

  // Operand decode for the accept cycle
  always_comb begin
    accept   = (state == IDLE) & start & ~flush;
    a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    a_neg    = a_signed & rs1[XLEN-1];
    b_neg    = b_signed & rs2[XLEN-1];
    mag_a    = a_neg ? -rs1 : rs1;
    mag_b    = b_neg ? -rs2 : rs2;
    is_div   = funct3[2];
    b_zero   = (rs2 == '0);
    ovf      = ~funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
    fast     = is_div & (b_zero | ovf);
    if (b_zero) begin
      fast_res = funct3[1] ? rs1 : '1;
    end else begin
      fast_res = funct3[1] ? '0 : rs1;
    end
  end

  // One iteration of each algorithm
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    div_ge   = {acc_hi, acc_lo[XLEN-1]} >= {1'b0, opb};
    div_diff = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]} - opb;
  end

  // Sign correction for FIX
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    mul_res  = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    if (op[1]) begin
      div_res = neg_rem ? -acc_hi : acc_hi;
    end else begin
      div_res = neg_res ? -acc_lo : acc_lo;
    end
    fix_res  = op[2] ? div_res : mul_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      busy <= (state_nxt == CALC) | (state_nxt == FIX);
      done <= (state_nxt == DONE);
      if (accept) begin
        op      <= funct3;
        cnt     <= '0;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        acc_hi  <= '0;
        acc_lo  <= mag_a;
        opb     <= mag_b;
        if (fast) result <= fast_res;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        if (op[2]) begin
          acc_hi <= div_ge ? div_diff : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
          acc_lo <= {acc_lo[XLEN-2:0], div_ge};
        end else begin
          acc_hi <= mul_sum[XLEN:1];
          acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
        end
      end else if ((state == FIX) && !flush) begin
        result <= fix_res;
      end
    end
  end

  assign stall = (start & (state == IDLE)) | busy;

endmodule
